// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: data width, opcodes and FSM states.
package alu_pkg;

    localparam int DATA_W = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 16-bit ALU datapath; results truncated to DATA_W bits.
module alu_arbiter_alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        opcode,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    // Decode the opcode into one of eight bitwise/arithmetic results.
    always_comb begin
        result = '0;
        case (opcode)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_SHL:  result = {a[DATA_W-2:0], 1'b0};
            OP_SHR:  result = {1'b0, a[DATA_W-1:1]};
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters, with a
// single tagged valid/ready response channel and a completed-op counter.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]  req_a,
    input  logic [NUM_REQ*DATA_W-1:0]  req_b,
    input  logic [NUM_REQ*3-1:0]       req_opcode,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_result,
    output logic [ID_W-1:0]            rsp_id,
    output logic                       rsp_zero,
    output logic [15:0]                op_count
);

    state_t              state;
    logic [ID_W-1:0]     ptr;
    logic [ID_W-1:0]     grant;
    logic [ID_W-1:0]     ptr_next;
    logic                found;
    logic                accept;

    logic [DATA_W-1:0]   a_p0;
    logic [DATA_W-1:0]   b_p0;
    logic [2:0]          opcode_p0;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_zero;

    // Pick the first valid requester scanning ptr, ptr+1, ... modulo NUM_REQ.
    always_comb begin
        int idx;
        found = 1'b0;
        grant = ptr;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = ID_W'(idx);
            end
        end
    end

    // Grant strobe is only offered in IDLE and never while reset is held.
    always_comb begin
        accept    = (state == IDLE) && found && !rst;
        ptr_next  = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        req_ready = '0;
        if (accept)
            req_ready[grant] = 1'b1;
    end

    // Operand capture stage; data registers need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0      <= req_a[DATA_W*grant +: DATA_W];
            b_p0      <= req_b[DATA_W*grant +: DATA_W];
            opcode_p0 <= req_opcode[3*grant +: 3];
        end
    end

    alu_arbiter_alu u_alu (
        .a      (a_p0),
        .b      (b_p0),
        .opcode (opcode_p0),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Control FSM with registered response outputs and completion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_id     <= '0;
            rsp_zero   <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        rsp_id <= grant;
                        ptr    <= ptr_next;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 16-bit combinational ALU datapath between NUM_REQ independent requesters. It arbitrates round-robin, captures the winner's operands and opcode, and executes the operation on registered inputs. It returns the registered result on a single tagged response channel with valid/ready backpressure. It sits between the requester blocks and the ALU datapath, which it instantiates.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(NUM_REQ), width of requester tag
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high
- req_a  in  NUM_REQ*16  operand A, requester i at [16*i+:16]
- req_b  in  NUM_REQ*16  operand B, same packing
- req_opcode  in  NUM_REQ*3  opcode, requester i at [3*i+:3]
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_result  out  16  ALU result
- rsp_id  out  ID_W  index of requester that issued the op
- rsp_zero  out  1  rsp_result == 0
- op_count  out  16  completed-response counter, wraps

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If any req_valid is high, the grant g is the first valid index scanning ptr, ptr+1, … mod NUM_REQ.
  - req_ready[g]=1 combinationally in this cycle only.
  - On the clock edge, capture req_a/req_b/req_opcode of g and g into rsp_id.
  - Set ptr ← (g+1) mod NUM_REQ, then go to EXEC.
  - With no valid request: stay in IDLE with all req_ready=0.
- EXEC: the ALU evaluates the captured operands. On the edge, rsp_result, rsp_zero ← ALU output. Go to RESP.
- RESP:
  - rsp_valid=1. rsp_result, rsp_id and rsp_zero are held stable while rsp_ready=0.
  - When rsp_valid&rsp_ready: op_count ← op_count+1 (0xFFFF wraps to 0x0000), then go to IDLE.
- req_ready is 0 in EXEC and RESP. A requester may drop or change req_valid while not granted.
- Opcodes:
  - 000 a+b; 001 a−b; 010 a&b; 011 a|b; 100 a^b; 101 ~a; 110 a<<1; 111 a>>1 (logical).
  - All results are truncated to 16 bits. No carry or overflow output.
- Reset (any state, including mid-op):
  - Next cycle: state=IDLE, ptr=0, rsp_valid=0, rsp_result=0, rsp_id=0, rsp_zero=0, op_count=0, req_ready=0 during reset.
  - An in-flight op is discarded. Requesters re-issue it.

## Timing
- Accept at edge T (IDLE, req_valid[g]&req_ready[g]) → EXEC in cycle T+1 → rsp_valid high from cycle T+2.
- Minimum latency from acceptance to response is 2 cycles.
- Response handshake at edge R → IDLE in cycle R+1, where a new request can be accepted. Peak throughput is one op per 3 cycles.
- rsp_valid stays high with stable data until a handshake occurs.
- op_count updates on the handshake edge.
- All outputs are registered except req_ready, which is a combinational decode of state, ptr and req_valid.

## Structure
- The shared package alu_pkg holds:
  - opcode localparams (OP_ADD … OP_SHR);
  - the state enum typedef (IDLE/EXEC/RESP);
  - the data width constant 16.
- One sub-module: the existing ALU datapath (ALU), instantiated once on the captured operand registers.
- A round-robin priority-select function may live locally or in alu_pkg. No further sub-modules.

## Test plan
- Single request: req0 a=0x0003, b=0x0005, op=000, rsp_ready=1 → rsp_valid exactly 2 cycles after acceptance, rsp_result=0x0008, rsp_id=0, rsp_zero=0, op_count=1.
- Wrap and zero flag:
  - req2 0x0000−0x0001 (op 001) → 0xFFFF, rsp_id=2.
  - a=0x00FF xor b=0x00FF (op 100) → 0x0000, rsp_zero=1.
- Fairness: all 4 req_valid held high, each with distinct operands → grant and rsp_id order 0,1,2,3,0,1. No requester is granted twice before every other valid requester has been granted once.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_result and rsp_id stable, all req_ready=0, op_count unchanged. rsp_ready=1 → op_count increments, IDLE next cycle.
- Reset mid-op: assert rst in EXEC, then separately in RESP → following cycle rsp_valid=0, op_count=0, state IDLE. The next grant starts at index 0.
- Shifts and counter wrap:
  - op 110 with a=0x8001 → 0x0002; op 111 with a=0x8001 → 0x4000.
  - Force 65536 completed responses → op_count returns to 0x0000.
